// File: rtl/def_pack.sv
// Shared definitions for the data memory responder: RV32I load/store width
// codes, the two-state handshake FSM encoding and the captured request bundle.
package def_pack;

  // funct3 width codes for loads (all five) and stores (first three)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Stores only know sb/sh/sw; loads additionally accept the unsigned forms.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering for the data memory: store byte enables and
// data shift, load lane select with sign/zero extension, and request checks
// (misalignment, out-of-range address, illegal funct3).
module dmem_align
  import def_pack::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  mem_req_t    req_i,
  input  logic [31:0] rd_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  // First byte address past the end of the array, widened so it cannot wrap.
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  logic [1:0]  off;
  logic [4:0]  sh_amt;
  logic [31:0] rd_shift;
  logic        misalign;
  logic        out_of_range;
  logic        bad_f3;

  // Error detection: alignment by width, range against array size, funct3 legality.
  always_comb begin
    off          = req_i.addr[1:0];
    sh_amt       = {off, 3'b000};
    out_of_range = ({1'b0, req_i.addr} >= BYTE_LIMIT);
    bad_f3       = !funct3_legal(req_i.we, req_i.funct3);
    misalign     = 1'b0;
    case (req_i.funct3)
      F3_H, F3_HU: misalign = req_i.addr[0];
      F3_W:        misalign = (off != 2'b00);
      default:     misalign = 1'b0;
    endcase
    err_o = misalign | out_of_range | bad_f3;
  end

  // Store path: place right-aligned data on its lanes and enable only those lanes.
  always_comb begin
    wdata_o = req_i.wdata << sh_amt;
    be_o    = 4'b0000;
    case (req_i.funct3)
      F3_B:    be_o = 4'b0001 << off;
      F3_H:    be_o = 4'b0011 << off;
      F3_W:    be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
    if (err_o || !req_i.we) begin
      be_o = 4'b0000;
    end
  end

  // Load path: bring the addressed lane down to bit 0, then extend by width.
  always_comb begin
    rd_shift = rd_word_i >> sh_amt;
    rdata_o  = 32'h0;
    case (req_i.funct3)
      F3_B:    rdata_o = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3_H:    rdata_o = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_W:    rdata_o = rd_shift;  // aligned, so the shift is zero
      F3_BU:   rdata_o = {24'h0, rd_shift[7:0]};
      F3_HU:   rdata_o = {16'h0, rd_shift[15:0]};
      default: rdata_o = 32'h0;
    endcase
    if (err_o || req_i.we) begin
      rdata_o = 32'h0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory slave with valid/ready request and response
// channels. A request is accepted in IDLE, stores commit on the acceptance
// edge, and a registered response is held in RESP until consumed.
// Optional feature macro: DMEM_LED_MIRROR_EN (mirror of memory word 0 on
// LED_MIRROR); when undefined LED_MIRROR is tied to zero.
module data_mem_responder
  import def_pack::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [31:0] LED_MIRROR
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  mem_req_t    req;
  logic        accept;
  logic [AW-1:0] word_idx;
  logic [31:0] rd_word;
  logic [3:0]  be;
  logic [3:0]  commit_be;
  logic [31:0] wdata_sh;
  logic [31:0] load_data;
  logic        align_err;

  // Word storage; no reset so contents survive RST.
  logic [31:0] mem [0:DEPTH_WORDS-1];

  // Ready is withheld during reset so a request on a reset edge is never taken.
  assign REQ_READY = (state_q == IDLE) && !RST;
  assign accept    = REQ_VALID && REQ_READY;

  // Only the low index bits matter; anything beyond the array is flagged as an error.
  assign word_idx  = REQ_ADDR[AW+1:2];
  assign rd_word   = mem[word_idx];

  // Bundle the incoming request for the lane-steering logic.
  always_comb begin
    req.we     = REQ_WE;
    req.funct3 = REQ_FUNCT3;
    req.addr   = REQ_ADDR;
    req.wdata  = REQ_WDATA;
  end

  dmem_align #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_align (
    .req_i    (req),
    .rd_word_i(rd_word),
    .be_o     (be),
    .wdata_o  (wdata_sh),
    .rdata_o  (load_data),
    .err_o    (align_err)
  );

  assign commit_be = accept ? be : 4'b0000;

  // Byte-lane write on the acceptance edge.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (commit_be[b]) begin
        mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Next-state and response capture: load the response on acceptance, clear it when consumed.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          rsp_err_d   = align_err;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;

`ifdef DMEM_LED_MIRROR_EN
  logic [31:0] led_q;
  logic [31:0] led_d;
  logic        word0_hit;

  // Out-of-range addresses alias onto low indices but carry no byte enables.
  assign word0_hit = (word_idx == '0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_led_lane
    assign led_d[8*gi +: 8] = (word0_hit && commit_be[gi]) ? wdata_sh[8*gi +: 8]
                                                           : led_q[8*gi +: 8];
  end

  // Mirror register follows every committed store to word 0 with the same lane merge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q <= 32'h0;
    end else begin
      led_q <= led_d;
    end
  end

  assign LED_MIRROR = led_q;
`else
  assign LED_MIRROR = 32'h0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-accurate reference memory
// predicts each response when the request is driven; the prediction is queued
// and compared when the response handshake happens.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [31:0] LED_MIRROR;

  always #5 CLK = ~CLK;

  data_mem_responder #(.DEPTH_WORDS(1024)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WE    (REQ_WE),
    .REQ_FUNCT3(REQ_FUNCT3),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .LED_MIRROR(LED_MIRROR)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [0:1023];
  logic [31:0] led_model;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] led_expected();
`ifdef DMEM_LED_MIRROR_EN
    return led_model;
`else
    return 32'h0;
`endif
  endfunction

  // Reference behaviour: error rules, lane merge on stores, extension on loads.
  task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output exp_t e);
    logic        bad;
    logic [31:0] w;
    logic [31:0] sh;
    int          o;
    int          idx;
    o   = int'(addr[1:0]);
    bad = (addr >= 32'd4096);
    case (f3)
      3'd0, 3'd4: ;
      3'd1, 3'd5: if (addr[0]) bad = 1'b1;
      3'd2:       if (addr[1:0] != 2'b00) bad = 1'b1;
      default:    bad = 1'b1;
    endcase
    if (we && (f3 == 3'd4 || f3 == 3'd5)) bad = 1'b1;
    e.err   = bad;
    e.rdata = 32'h0;
    if (!bad) begin
      idx = int'(addr[11:2]);
      w   = model_mem[idx];
      if (we) begin
        case (f3)
          3'd0:    w[8*o +: 8]  = wdata[7:0];
          3'd1:    w[8*o +: 16] = wdata[15:0];
          default: w = wdata;
        endcase
        model_mem[idx] = w;
        if (idx == 0) led_model = w;
      end else begin
        sh = w >> (8 * o);
        case (f3)
          3'd0:    e.rdata = {{24{sh[7]}}, sh[7:0]};
          3'd1:    e.rdata = {{16{sh[15]}}, sh[15:0]};
          3'd4:    e.rdata = {24'h0, sh[7:0]};
          3'd5:    e.rdata = {16'h0, sh[15:0]};
          default: e.rdata = w;
        endcase
      end
    end
  endtask

  // One request/response transaction; optional response stall and a blocked
  // store presented while the responder is busy.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall, input bit intrude);
    exp_t        e;
    logic [31:0] held_rdata;
    logic        held_err;
    int          n;
    @(negedge CLK);
    REQ_WE     = we;
    REQ_FUNCT3 = f3;
    REQ_ADDR   = addr;
    REQ_WDATA  = wdata;
    REQ_VALID  = 1'b1;
    n = 0;
    while (!REQ_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) begin
      check("req_ready_timeout", {31'b0, REQ_READY}, 32'd1);
      REQ_VALID = 1'b0;
      return;
    end
    predict(we, f3, addr, wdata, e);
    sb_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("rsp_valid_lat1", {31'b0, RSP_VALID}, 32'd1);
    check("led_mirror", LED_MIRROR, led_expected());
    held_rdata = RSP_RDATA;
    held_err   = RSP_ERR;
    for (int i = 0; i < stall; i++) begin
      if (intrude) begin
        REQ_VALID  = 1'b1;
        REQ_WE     = 1'b1;
        REQ_FUNCT3 = 3'd2;
        REQ_ADDR   = addr;
        REQ_WDATA  = 32'h5555AAAA;
      end
      @(negedge CLK);
      check("stall_valid", {31'b0, RSP_VALID}, 32'd1);
      check("stall_rdata", RSP_RDATA, held_rdata);
      check("stall_err", {31'b0, RSP_ERR}, {31'b0, held_err});
      check("stall_req_ready", {31'b0, REQ_READY}, 32'd0);
    end
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    if (RSP_VALID && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_rdata", RSP_RDATA, e.rdata);
      check("rsp_err", {31'b0, RSP_ERR}, {31'b0, e.err});
    end else begin
      check("rsp_present", {31'b0, RSP_VALID}, 32'd1);
    end
    $display("txn we=%0d f3=%0d addr=%08h wdata=%08h stall=%0d -> rdata=%08h err=%0d",
             we, f3, addr, wdata, stall, RSP_RDATA, RSP_ERR);
    @(negedge CLK);
    RSP_READY = 1'b0;
    check("rsp_valid_drop", {31'b0, RSP_VALID}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
    led_model  = 32'h0;
    RST        = 1'b1;
    REQ_VALID  = 1'b0;
    REQ_WE     = 1'b0;
    REQ_FUNCT3 = 3'd0;
    REQ_ADDR   = 32'h0;
    REQ_WDATA  = 32'h0;
    RSP_READY  = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_req_ready", {31'b0, REQ_READY}, 32'd0);
    check("rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
    check("rst_rsp_rdata", RSP_RDATA, 32'd0);
    check("rst_rsp_err", {31'b0, RSP_ERR}, 32'd0);
    check("rst_led", LED_MIRROR, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", {31'b0, REQ_READY}, 32'd1);

    // Basic word and byte traffic
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd0, 32'h13, 32'h80, 0, 1'b0);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
    // Error cases leave memory untouched
    do_req(1'b0, 3'd1, 32'h11, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd2, 32'h1000, 32'h11111111, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'h12, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd3, 32'h10, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd4, 32'h10, 32'h22222222, 0, 1'b0);
    do_req(1'b1, 3'd1, 32'h13, 32'h3333, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
    // Halfwords, word 0 mirror, top-of-memory boundary
    do_req(1'b1, 3'd1, 32'h2, 32'h1234, 0, 1'b0);
    do_req(1'b0, 3'd1, 32'h2, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd0, 32'h0, 32'hF0, 0, 1'b0);
    do_req(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 0, 1'b0);
    do_req(1'b0, 3'd1, 32'h22, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd5, 32'h22, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd0, 32'h21, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd4, 32'h20, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd2, 32'hFFC, 32'h01234567, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'hFFC, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd0, 32'hFFF, 32'h0, 0, 1'b0);
    // Stalled response with a store presented while busy (must be ignored)
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, 1'b1);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);

    // Reset while a response is pending, with a store offered on the reset edge
    @(negedge CLK);
    REQ_WE = 1'b0; REQ_FUNCT3 = 3'd2; REQ_ADDR = 32'h10; REQ_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("pre_rst_valid", {31'b0, RSP_VALID}, 32'd1);
    RST = 1'b1;
    REQ_WE = 1'b1; REQ_FUNCT3 = 3'd2; REQ_ADDR = 32'h20; REQ_WDATA = 32'hBAD0BAD0;
    REQ_VALID = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    RST = 1'b0;
    led_model = 32'h0;
    check("rst_resp_valid", {31'b0, RSP_VALID}, 32'd0);
    check("rst_resp_led", LED_MIRROR, 32'd0);
    @(negedge CLK);
    check("rst_resp_ready", {31'b0, REQ_READY}, 32'd1);
    check("rst_resp_valid2", {31'b0, RSP_VALID}, 32'd0);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);

    // Randomised mix over a pre-initialised region
    for (int a = 32'h40; a < 32'h80; a += 4) do_req(1'b1, 3'd2, a, $urandom, 0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      rwe   = 1'($urandom_range(0, 1));
      rf3   = rwe ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) rf3 = 3'($urandom_range(6, 7));
      raddr = 32'h40 + 32'($urandom_range(0, 63));
      do_req(rwe, rf3, raddr, $urandom, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
